// File: rtl/store_unit.sv
// rtl/store_unit.sv - store alignment unit: SB/SH/SW onto byte lanes, one or two word writes
// Misaligned halfwords/words are split into two word-aligned writes over a req/ack handshake.
module store_unit #(
  parameter int         DATA_W   = 32,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] storeval,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WR0, S_WR1, S_FIN} state_t;

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [DATA_W-1:0] r_address;
  logic [DATA_W-1:0] r_storeval;

  logic                w_in_idle;
  logic [2:0]          w_funct3;
  logic [DATA_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_val;
  logic [1:0]          w_k;
  logic [3:0]          w_mask;
  logic [DATA_W-1:0]   w_val_m;
  logic [7:0]          w_be_full;
  logic [2*DATA_W-1:0] w_data_full;
  logic                w_legal;
  logic                w_split;
  logic                w_unused;

  // In IDLE the lane logic looks at the live inputs so word 0 can be registered on the
  // start edge; afterwards it works from the latched operands.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_funct3  = w_in_idle ? instruction[14:12] : r_funct3;
  assign w_addr    = w_in_idle ? address : r_address;
  assign w_val     = w_in_idle ? storeval : r_storeval;
  assign w_k       = w_addr[1:0];

  always_comb begin
    w_mask  = 4'b1111;
    w_val_m = w_val;
    case (w_funct3)
      3'b000: begin
        w_mask  = 4'b0001;
        w_val_m = {{(DATA_W-8){1'b0}}, w_val[7:0]};
      end
      3'b001: begin
        w_mask  = 4'b0011;
        w_val_m = {{(DATA_W-16){1'b0}}, w_val[15:0]};
      end
      default: ;
    endcase
  end

  // Shift across a double word: the low half is word 0, the high half spills into word 1.
  assign w_be_full   = {4'b0000, w_mask} << w_k;
  assign w_data_full = {{DATA_W{1'b0}}, w_val_m} << {w_k, 3'b000};
  assign w_split     = |w_be_full[7:4];
  assign w_legal     = (instruction[6:0] == STORE_OP) && !instruction[14] &&
                       !(instruction[13] && instruction[12]);
  assign w_unused    = ^{instruction[DATA_W-1:15], instruction[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_funct3   <= 3'b000;
      r_address  <= '0;
      r_storeval <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct3   <= instruction[14:12];
            r_address  <= address;
            r_storeval <= storeval;
            busy       <= 1'b1;
            if (w_legal) begin
              r_state   <= S_WR0;
              mem_req   <= 1'b1;
              mem_addr  <= {address[DATA_W-1:2], 2'b00};
              mem_wdata <= w_data_full[DATA_W-1:0];
              mem_be    <= w_be_full[3:0];
            end else begin
              r_state <= S_FIN;
              done    <= 1'b1;
              err     <= 1'b1;
            end
          end
        end
        S_WR0: begin
          if (mem_ack) begin
            if (w_split) begin
              r_state   <= S_WR1;
              mem_addr  <= mem_addr + DATA_W'(4);
              mem_wdata <= w_data_full[2*DATA_W-1:DATA_W];
              mem_be    <= w_be_full[7:4];
            end else begin
              r_state   <= S_FIN;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= 4'b0000;
              done      <= 1'b1;
            end
          end
        end
        S_WR1: begin
          if (mem_ack) begin
            r_state   <= S_FIN;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            done      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] address;
  logic [31:0] storeval;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
    .address(address), .storeval(storeval), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] op);
    return {7'h00, 5'd2, 5'd1, f3, 5'h00, op};
  endfunction

  // Drives start for one sampling edge; returns at the first negedge after it.
  task automatic do_store(input logic [2:0] f3, input logic [6:0] op,
                          input logic [31:0] a, input logic [31:0] v);
    instruction = mk_instr(f3, op);
    address     = a;
    storeval    = v;
    start       = 1'b1;
    t_start     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d, input int delay);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < delay; i++) begin
      check($sformatf("%s_addr_w%0d", tag, i), mem_addr, a);
      check($sformatf("%s_be_w%0d", tag, i), {28'b0, mem_be}, {28'b0, be});
      check($sformatf("%s_data_w%0d", tag, i), mem_wdata, d);
      @(negedge clk);
    end
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_be"}, {28'b0, mem_be}, {28'b0, be});
    check({tag, "_data"}, mem_wdata, d);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic exp_err);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_latency"}, cyc - t_start, exp_lat);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_busy_fin"}, {31'b0, busy}, 32'd1);
    check({tag, "_req_fin"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_addr_fin"}, mem_addr, 32'd0);
    check({tag, "_be_fin"}, {28'b0, mem_be}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_err_pulse"}, {31'b0, err}, 32'd0);
    check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_data"}, mem_wdata, 32'd0);
    check({tag, "_be"}, {28'b0, mem_be}, 32'd0);
  endtask

  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_LD = 7'b0000011;

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    mem_ack     = 1'b0;
    instruction = 32'h0;
    address     = 32'h0;
    storeval    = 32'h0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_store(3'b010, OP_ST, 32'h0000_0100, 32'hDEAD_BEEF);
    expect_write("sw_aligned", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0);
    wait_done("sw_aligned", 2, 1'b0);

    do_store(3'b000, OP_ST, 32'h0000_0203, 32'h0000_00A5);
    expect_write("sb_lane3", 32'h0000_0200, 4'b1000, 32'hA500_0000, 0);
    wait_done("sb_lane3", 2, 1'b0);

    do_store(3'b000, OP_ST, 32'h0000_0000, 32'hFFFF_FF5A);
    expect_write("sb_lane0", 32'h0000_0000, 4'b0001, 32'h0000_005A, 1);
    wait_done("sb_lane0", 3, 1'b0);

    do_store(3'b001, OP_ST, 32'h0000_1003, 32'h0000_1234);
    expect_write("sh_split0", 32'h0000_1000, 4'b1000, 32'h3400_0000, 0);
    expect_write("sh_split1", 32'h0000_1004, 4'b0001, 32'h0000_0012, 0);
    wait_done("sh_split", 3, 1'b0);

    do_store(3'b001, OP_ST, 32'h0000_0002, 32'h5555_ABCD);
    expect_write("sh_k2", 32'h0000_0000, 4'b1100, 32'hABCD_0000, 0);
    wait_done("sh_k2", 2, 1'b0);

    do_store(3'b010, OP_ST, 32'hFFFF_FFFE, 32'h1122_3344);
    expect_write("sw_wrap0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, 3);
    expect_write("sw_wrap1", 32'h0000_0000, 4'b0011, 32'h0000_1122, 3);
    wait_done("sw_wrap", 9, 1'b0);

    do_store(3'b010, OP_ST, 32'h0000_0005, 32'hAABB_CCDD);
    expect_write("sw_k1_0", 32'h0000_0004, 4'b1110, 32'hBBCC_DD00, 0);
    expect_write("sw_k1_1", 32'h0000_0008, 4'b0001, 32'h0000_00AA, 0);
    wait_done("sw_k1", 3, 1'b0);

    do_store(3'b011, OP_ST, 32'h0000_0040, 32'h1234_5678);
    wait_done("bad_funct3", 1, 1'b1);

    do_store(3'b010, OP_LD, 32'h0000_0040, 32'h1234_5678);
    wait_done("bad_opcode", 1, 1'b1);
    check_quiet("after_bad");

    // Reset while WR0 waits for ack.
    do_store(3'b010, OP_ST, 32'h0000_0100, 32'hCAFE_F00D);
    check("rst_pre_req", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_quiet("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("rst_after");

    do_store(3'b000, OP_ST, 32'h0000_0101, 32'h0000_0077);
    expect_write("post_rst", 32'h0000_0100, 4'b0010, 32'h0000_7700, 0);
    wait_done("post_rst", 2, 1'b0);

    // A second start while busy, with changed operands, must be ignored.
    do_store(3'b010, OP_ST, 32'h0000_0300, 32'hCAFE_F00D);
    instruction = mk_instr(3'b000, OP_ST);
    address     = 32'h0000_0007;
    storeval    = 32'h0000_0099;
    start       = 1'b1;
    expect_write("busy_start", 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 2);
    start = 1'b0;
    wait_done("busy_start", 4, 1'b0);
    @(negedge clk);
    check_quiet("busy_start_ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
